// File: rtl/mem_port_rr_arbiter.sv
// Round-robin arbiter sharing one memory request/response port among N requestors.
// At most one transaction is in flight; the grant is held until its response returns.
module mem_port_rr_arbiter #(
  parameter int unsigned N      = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned GW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N-1:0]          io_requestor_req_valid,
  output logic [N-1:0]          io_requestor_req_ready,
  input  logic [N*ADDR_W-1:0]   io_requestor_req_bits_addr,
  input  logic [N-1:0]          io_requestor_req_bits_rw,
  input  logic [N*DATA_W-1:0]   io_requestor_req_bits_data,
  output logic [N-1:0]          io_requestor_resp_valid,
  output logic [DATA_W-1:0]     io_requestor_resp_bits_data,
  output logic                  io_mem_req_valid,
  input  logic                  io_mem_req_ready,
  output logic [ADDR_W-1:0]     io_mem_req_bits_addr,
  output logic                  io_mem_req_bits_rw,
  output logic [DATA_W-1:0]     io_mem_req_bits_data,
  input  logic                  io_mem_resp_valid,
  input  logic [DATA_W-1:0]     io_mem_resp_bits_data,
  output logic                  io_busy,
  output logic [GW-1:0]         io_grant_id
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] data;
  } req_t;

  state_t        state, state_nxt;
  logic          run;
  logic [GW-1:0] ptr, ptr_nxt;
  logic [GW-1:0] grant, grant_nxt;
  req_t          req_q, req_nxt;
  logic          any_valid;
  logic [GW-1:0] winner;
  logic [GW-1:0] scan_idx;

  // run holds arbitration off until the first edge after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run   <= 1'b0;
      state <= IDLE;
      ptr   <= '0;
      grant <= '0;
      req_q <= '0;
    end else begin
      run   <= 1'b1;
      state <= state_nxt;
      ptr   <= ptr_nxt;
      grant <= grant_nxt;
      req_q <= req_nxt;
    end
  end

  // First valid requestor scanning from ptr upward with wrap
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = GW'((32'(ptr) + k) % N);
      if (!any_valid && io_requestor_req_valid[scan_idx]) begin
        any_valid = 1'b1;
        winner    = scan_idx;
      end
    end
  end

  // Next-state and captured-request logic
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant;
    req_nxt   = req_q;
    case (state)
      IDLE: begin
        if (run && any_valid) begin
          grant_nxt = winner;
          state_nxt = ISSUE;
          for (int unsigned i = 0; i < N; i++) begin
            if (winner == GW'(i)) begin
              req_nxt.addr = io_requestor_req_bits_addr[i*ADDR_W +: ADDR_W];
              req_nxt.rw   = io_requestor_req_bits_rw[i];
              req_nxt.data = io_requestor_req_bits_data[i*DATA_W +: DATA_W];
            end
          end
        end
      end
      ISSUE: begin
        if (io_mem_req_ready) state_nxt = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (io_mem_resp_valid) begin
          ptr_nxt   = (grant == GW'(N - 1)) ? '0 : grant + GW'(1);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake strobes decoded from state
  always_comb begin
    io_requestor_req_ready  = '0;
    io_requestor_resp_valid = '0;
    io_mem_req_valid        = 1'b0;
    case (state)
      IDLE:      if (run && any_valid) io_requestor_req_ready[winner] = 1'b1;
      ISSUE:     io_mem_req_valid = 1'b1;
      WAIT_RESP: if (io_mem_resp_valid) io_requestor_resp_valid[grant] = 1'b1;
      default:   io_mem_req_valid = 1'b0;
    endcase
  end

  assign io_mem_req_bits_addr        = req_q.addr;
  assign io_mem_req_bits_rw          = req_q.rw;
  assign io_mem_req_bits_data        = req_q.data;
  assign io_requestor_resp_bits_data = io_mem_resp_bits_data;
  assign io_busy                     = (state != IDLE);
  assign io_grant_id                 = grant;

endmodule

// File: tb/tb_mem_port_rr_arbiter.sv
// Directed bench for mem_port_rr_arbiter: stimulus queues expected memory requests
// and requestor responses, a negedge monitor pops and compares them.
module tb_mem_port_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned GW = 2;

  localparam logic [31:0] ADDR_TBL [4] = '{32'h0000_1000, 32'h0000_1100, 32'h0000_1200, 32'h0000_1300};
  localparam logic        RW_TBL   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [31:0] DATA_TBL [4] = '{32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3};
  localparam int          RR_ORDER [5] = '{0, 1, 2, 3, 0};
  localparam logic [31:0] RR_RDATA [5] = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003, 32'hD000_0004};

  typedef struct packed {
    logic [31:0] addr;
    logic        rw;
    logic [31:0] data;
  } mreq_t;

  typedef struct packed {
    logic [3:0]  vec;
    logic [31:0] data;
  } resp_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_rw;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_data;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [AW-1:0]   mem_req_addr;
  logic            mem_req_rw;
  logic [DW-1:0]   mem_req_data;
  logic            mem_resp_valid;
  logic [DW-1:0]   mem_resp_data;
  logic            busy;
  logic [GW-1:0]   grant_id;

  mreq_t exp_mreq[$];
  resp_t exp_resp[$];
  int    checks = 0;
  int    errors = 0;

  mem_port_rr_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk                         (clk),
    .reset_n                     (reset_n),
    .io_requestor_req_valid      (req_valid),
    .io_requestor_req_ready      (req_ready),
    .io_requestor_req_bits_addr  (req_addr),
    .io_requestor_req_bits_rw    (req_rw),
    .io_requestor_req_bits_data  (req_data),
    .io_requestor_resp_valid     (resp_valid),
    .io_requestor_resp_bits_data (resp_data),
    .io_mem_req_valid            (mem_req_valid),
    .io_mem_req_ready            (mem_req_ready),
    .io_mem_req_bits_addr        (mem_req_addr),
    .io_mem_req_bits_rw          (mem_req_rw),
    .io_mem_req_bits_data        (mem_req_data),
    .io_mem_resp_valid           (mem_resp_valid),
    .io_mem_resp_bits_data       (mem_resp_data),
    .io_busy                     (busy),
    .io_grant_id                 (grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_txn(input logic [31:0] a, input logic rw, input logic [31:0] d);
    mreq_t m;
    m.addr = a;
    m.rw   = rw;
    m.data = d;
    exp_mreq.push_back(m);
  endtask

  task automatic push_resp(input logic [3:0] v, input logic [31:0] d);
    resp_t r;
    r.vec  = v;
    r.data = d;
    exp_resp.push_back(r);
  endtask

  // Waits (bounded) for the memory-side handshake; returns at that negedge
  task automatic wait_hs();
    int n;
    n = 0;
    @(negedge clk);
    while (!(mem_req_valid && mem_req_ready) && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 30) begin
      errors++;
      $display("FAIL hs_timeout actual=no_handshake required=handshake");
    end
  endtask

  // Returns a response in the first WAIT_RESP cycle after the handshake
  task automatic complete(input logic [31:0] rdata);
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = rdata;
    tick();
    mem_resp_valid = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mem_req_valid && mem_req_ready) begin
      if (exp_mreq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_req_unexpected actual=%0h required=none", mem_req_addr);
      end else begin
        mreq_t m;
        m = exp_mreq.pop_front();
        chk("mem_req", 128'({mem_req_addr, mem_req_rw, mem_req_data}), 128'(m));
      end
    end
    if (resp_valid != '0) begin
      if (exp_resp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected actual=%0h required=none", resp_valid);
      end else begin
        resp_t r;
        r = exp_resp.pop_front();
        chk("resp", 128'({resp_valid, resp_data}), 128'(r));
      end
    end
    chk("ready_rule", 128'(req_ready != '0 && (busy || $countones(req_ready) != 1)), 128'(0));
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    req_valid      = '1;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*AW +: AW] = ADDR_TBL[i];
      req_rw[i]            = RW_TBL[i];
      req_data[i*DW +: DW] = DATA_TBL[i];
    end

    // Reset with every requestor valid
    repeat (3) @(negedge clk);
    chk("rst_ready", 128'(req_ready), 128'(0));
    chk("rst_mem_valid", 128'(mem_req_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_grant", 128'(grant_id), 128'(0));
    chk("rst_fields", 128'({mem_req_addr, mem_req_rw, mem_req_data}), 128'(0));
    chk("rst_resp", 128'(resp_valid), 128'(0));

    for (int n = 0; n < 5; n++) begin
      push_txn(ADDR_TBL[RR_ORDER[n]], RW_TBL[RR_ORDER[n]], DATA_TBL[RR_ORDER[n]]);
      push_resp(4'(1 << RR_ORDER[n]), RR_RDATA[n]);
    end
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", 128'(req_ready), 128'(0));
    @(negedge clk);
    chk("ready_after_release", 128'(req_ready), 128'(4'b0001));
    chk("grant_after_release", 128'(grant_id), 128'(0));

    // Round-robin with all four requestors valid
    for (int n = 0; n < 5; n++) begin
      wait_hs();
      chk("rr_grant", 128'(grant_id), 128'(RR_ORDER[n]));
      complete(RR_RDATA[n]);
      if (n == 4) req_valid = '0;
    end

    // Single read from requestor 2 (ptr now 1)
    req_addr[2*AW +: AW] = 32'h0000_0100;
    req_rw[2]            = 1'b0;
    req_data[2*DW +: DW] = 32'h0;
    req_valid            = 4'b0100;
    push_txn(32'h0000_0100, 1'b0, 32'h0);
    push_resp(4'b0100, 32'h0000_CAFE);
    @(negedge clk);
    chk("single_ready", 128'(req_ready), 128'(4'b0100));
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("single_mem_valid", 128'(mem_req_valid), 128'(1));
    chk("single_grant", 128'(grant_id), 128'(2));
    tick();
    @(negedge clk);
    chk("single_wait_busy", 128'(busy), 128'(1));
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_CAFE;
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("single_done_busy", 128'(busy), 128'(0));

    // Backpressure on requestor 3 (ptr 3), with spurious responses in ISSUE
    tick();
    mem_req_ready = 1'b0;
    req_valid     = 4'b1010;
    push_txn(32'h0000_1300, 1'b1, 32'h0000_00A3);
    push_resp(4'b1000, 32'h0000_BEEF);
    @(negedge clk);
    chk("bp_ready", 128'(req_ready), 128'(4'b1000));
    tick();
    for (int c = 1; c <= 5; c++) begin
      mem_resp_valid = (c == 3);
      mem_resp_data  = 32'h0000_DEAD;
      @(negedge clk);
      chk("bp_hold", 128'({mem_req_valid, mem_req_addr, mem_req_rw, mem_req_data}),
          128'({1'b1, 32'h0000_1300, 1'b1, 32'h0000_00A3}));
      chk("bp_no_ready", 128'(req_ready), 128'(0));
      tick();
    end
    mem_resp_valid = 1'b1;
    mem_req_ready  = 1'b1;
    @(negedge clk);
    chk("bp_hs_busy", 128'(busy), 128'(1));
    tick();
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;
    @(negedge clk);
    chk("bp_still_waiting", 128'({busy, mem_req_valid}), 128'(2'b10));
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_BEEF;
    tick();
    mem_resp_valid = 1'b0;
    req_valid      = '0;

    // Spurious response in IDLE, then wrap check (ptr 0 picks requestor 1)
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_5555;
    mem_req_ready  = 1'b1;
    @(negedge clk);
    chk("idle_spur_busy", 128'(busy), 128'(0));
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("idle_grant_retained", 128'(grant_id), 128'(3));
    tick();
    req_valid = 4'b1010;
    push_txn(32'h0000_1100, 1'b1, 32'h0000_00A1);
    push_resp(4'b0010, 32'h0000_1234);
    @(negedge clk);
    chk("wrap_ready", 128'(req_ready), 128'(4'b0010));
    wait_hs();
    complete(32'h0000_1234);
    req_valid = '0;

    // Reset in WAIT_RESP drops the transaction and clears ptr (was 2)
    req_valid = 4'b1000;
    push_txn(32'h0000_1300, 1'b1, 32'h0000_00A3);
    wait_hs();
    tick();
    req_valid = '0;
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_outputs", 128'({mem_req_valid, grant_id, mem_req_addr}), 128'(0));
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_7777;
    tick();
    mem_resp_valid = 1'b0;
    tick();
    reset_n        = 1'b1;
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    req_valid      = 4'b1010;
    push_txn(32'h0000_1100, 1'b1, 32'h0000_00A1);
    push_resp(4'b0010, 32'h0000_4321);
    @(negedge clk);
    chk("ptr_after_reset", 128'(req_ready), 128'(4'b0010));
    wait_hs();
    complete(32'h0000_4321);
    req_valid = '0;

    repeat (2) @(negedge clk);
    chk("mreq_queue_empty", 128'(exp_mreq.size()), 128'(0));
    chk("resp_queue_empty", 128'(exp_resp.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
